// File: rtl/sym_eval_pipe.sv
// ---------------------------------------------------------------------------
// sym_eval_pipe
//
// Two-stage pipelined evaluator for totally symmetric Boolean functions.
// The result for an N-bit vector x depends only on popcount(x):
//     y0 = mask[popcount(x)]
// The acceptance mask is runtime-programmable. Its reset value 'h078
// reproduces the classic 9sym function, which is true for popcount 3..6.
//
// Pipeline
//   S1 : partial popcounts of the lower and upper halves of x. Also holds
//        a private copy of the mask sampled in the accept cycle.
//   S2 : count = lo + hi, y0 = mask_copy[count]
//
// Optional feature (macro SYM_EVAL_HIT_CNT_EN)
//   Adds hit_clr (in) and hit_cnt[31:0] (out). hit_cnt is a saturating
//   count of delivered transactions whose y0 is 1. When hit_clr and an
//   increment occur in the same cycle, the clear takes priority.
//
// Ports
//   clk        in   1     clock, rising edge
//   rst        in   1     synchronous active-high reset
//   in_valid   in   1     x is valid
//   in_ready   out  1     block accepts x this cycle
//                         (combinational from out_ready)
//   x          in   N     input vector
//   cfg_we     in   1     load cfg_mask into the mask register
//   cfg_mask   in   N+1   new acceptance mask
//   mask_q     out  N+1   current mask register
//   out_valid  out  1     y0/count valid
//   out_ready  in   1     downstream accepts the result
//   y0         out  1     mask[popcount(x)]
//   count      out  CW    popcount(x)
// ---------------------------------------------------------------------------
module sym_eval_pipe #(
    parameter int         N            = 9,
    parameter int         CW           = $clog2(N + 1),
    parameter logic [N:0] DEFAULT_MASK = (N + 1)'('h078)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  x,
    input  logic          cfg_we,
    input  logic [N:0]    cfg_mask,
    output logic [N:0]    mask_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          y0,
    output logic [CW-1:0] count
`ifdef SYM_EVAL_HIT_CNT_EN
    ,
    input  logic          hit_clr,
    output logic [31:0]   hit_cnt
`endif
);

    // Lower half has floor(N/2) bits; for odd N the upper half gets the
    // extra bit.
    localparam int LO = N / 2;

    logic [N:0]    r_mask;

    logic          r_s1_valid;
    logic [CW-1:0] r_s1_cnt_lo;
    logic [CW-1:0] r_s1_cnt_hi;
    logic [N:0]    r_s1_mask;

    logic          r_s2_valid;
    logic [CW-1:0] r_count;
    logic          r_y0;

    logic          w_s1_adv;
    logic          w_s2_adv;
    logic [CW-1:0] w_cnt_lo;
    logic [CW-1:0] w_cnt_hi;
    logic [CW-1:0] w_sum;

    // Partial popcounts. CW bits each is ample, because either half holds
    // at most N ones.
    always_comb begin
        w_cnt_lo = '0;
        w_cnt_hi = '0;
        for (int i = 0; i < LO; i++) begin
            w_cnt_lo = w_cnt_lo + CW'(x[i]);
        end
        for (int i = LO; i < N; i++) begin
            w_cnt_hi = w_cnt_hi + CW'(x[i]);
        end
    end

    // The sum of the two partials is at most N, so it cannot overflow CW
    // bits.
    assign w_sum = r_s1_cnt_lo + r_s1_cnt_hi;

    // A stage may load when it is empty or its content moves on this cycle.
    // There is no skid buffer. As a result, in_ready depends
    // combinationally on out_ready through both stages. In exchange, a
    // full pipeline drains and refills in the same cycle without a bubble.
    assign w_s2_adv = !r_s2_valid || out_ready;
    assign w_s1_adv = !r_s1_valid || w_s2_adv;
    assign in_ready = w_s1_adv;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask      <= DEFAULT_MASK;
            r_s1_valid  <= 1'b0;
            r_s1_cnt_lo <= '0;
            r_s1_cnt_hi <= '0;
            r_s1_mask   <= DEFAULT_MASK;
            r_s2_valid  <= 1'b0;
            r_count     <= '0;
            r_y0        <= 1'b0;
        end else begin
            // Mask writes are independent of backpressure. An accept in the
            // same cycle captures the old r_mask below.
            if (cfg_we) begin
                r_mask <= cfg_mask;
            end

            if (w_s1_adv) begin
                r_s1_valid <= in_valid;
                if (in_valid) begin
                    r_s1_cnt_lo <= w_cnt_lo;
                    r_s1_cnt_hi <= w_cnt_hi;
                    r_s1_mask   <= r_mask;
                end
            end

            // Data registers load only on real transactions, so y0/count
            // keep their last delivered values while the stage is empty.
            if (w_s2_adv) begin
                r_s2_valid <= r_s1_valid;
                if (r_s1_valid) begin
                    r_count <= w_sum;
                    r_y0    <= r_s1_mask[w_sum];
                end
            end
        end
    end

    assign mask_q    = r_mask;
    assign out_valid = r_s2_valid;
    assign y0        = r_y0;
    assign count     = r_count;

`ifdef SYM_EVAL_HIT_CNT_EN
    logic [31:0] r_hit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hit_cnt <= '0;
        end else if (hit_clr) begin
            r_hit_cnt <= '0;
        end else if (r_s2_valid && out_ready && r_y0 && (r_hit_cnt != 32'hFFFF_FFFF)) begin
            r_hit_cnt <= r_hit_cnt + 32'd1;
        end
    end

    assign hit_cnt = r_hit_cnt;
`endif

endmodule

// File: tb/tb_sym_eval_pipe.sv
// ---------------------------------------------------------------------------
// tb_sym_eval_pipe
//
// Scoreboard bench for sym_eval_pipe with N = 9.
//
// Each accepted vector pushes its expected {count, y0, accept cycle} into a
// queue. The expected values come from a bench-side mask model and
// $countones. Each delivered result pops one entry and compares against it.
//
// Define SYM_EVAL_HIT_CNT_EN to include the hit counter checks.
// ---------------------------------------------------------------------------
module tb_sym_eval_pipe;

    localparam int         N    = 9;
    localparam int         CW   = 4;
    localparam logic [N:0] DEF_MASK = 10'h078;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [N-1:0]  x;
    logic          cfg_we;
    logic [N:0]    cfg_mask;
    logic [N:0]    mask_q;
    logic          out_valid;
    logic          out_ready;
    logic          y0;
    logic [CW-1:0] count;
    logic          hit_clr;
`ifdef SYM_EVAL_HIT_CNT_EN
    logic [31:0]   hit_cnt;
`endif

    sym_eval_pipe #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x         (x),
        .cfg_we    (cfg_we),
        .cfg_mask  (cfg_mask),
        .mask_q    (mask_q),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y0        (y0),
        .count     (count)
`ifdef SYM_EVAL_HIT_CNT_EN
        ,
        .hit_clr   (hit_clr),
        .hit_cnt   (hit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [CW-1:0] cnt;
        logic          y0;
        int            acc_cyc;
    } exp_t;

    exp_t        exp_q[$];
    logic [N:0]  model_mask;
    logic [31:0] model_hits;
    int          cyc;
    int          n_checks;
    int          n_fail;
    int          n_deliv;
    int          last_deliv;
    logic        chk_lat;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int k = 0; k < 40 && exp_q.size() != 0; k++) begin
            @(negedge clk);
        end
        check("drain_left", 64'(exp_q.size()), 64'd0);
        tick();
    endtask

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor / scoreboard. It runs on the falling edge, when inputs and
    // outputs are stable.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            model_mask = DEF_MASK;
            model_hits = 0;
        end else begin
            if (out_valid && exp_q.size() == 0) begin
                check("stale_out", 64'(out_valid), 64'd0);
            end else if (out_valid && out_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                check("count", 64'(count), 64'(e.cnt));
                check("y0", 64'(y0), 64'(e.y0));
                if (chk_lat) check("latency", 64'(cyc - e.acc_cyc), 64'd2);
                n_deliv++;
                last_deliv = cyc;
                if (e.y0 && model_hits != 32'hFFFF_FFFF) model_hits = model_hits + 1;
            end
            if (hit_clr) model_hits = 0;
            if (in_valid && in_ready) begin
                exp_t n;
                int   pc;
                pc        = $countones(x);
                n.cnt     = CW'(pc);
                n.y0      = model_mask[pc];
                n.acc_cyc = cyc;
                exp_q.push_back(n);
            end
            if (cfg_we) model_mask = cfg_mask;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    logic [N-1:0] s1_vec [5];
    int           t0;
    int           d0;

    initial begin
        n_checks = 0; n_fail = 0; n_deliv = 0; last_deliv = 0;
        model_mask = DEF_MASK; model_hits = 0; chk_lat = 1'b0;
        rst = 1'b1; in_valid = 1'b0; x = '0; cfg_we = 1'b0; cfg_mask = '0;
        out_ready = 1'b1; hit_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_y0", 64'(y0), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        check("rst_mask_q", 64'(mask_q), 64'h078);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        tick();

        // 1: 9sym default vectors
        s1_vec[0] = 9'h000; s1_vec[1] = 9'h007; s1_vec[2] = 9'h03F;
        s1_vec[3] = 9'h07F; s1_vec[4] = 9'h1FF;
        chk_lat = 1'b1;
        for (int i = 0; i < 5; i++) begin
            x = s1_vec[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        drain();
`ifdef SYM_EVAL_HIT_CNT_EN
        check("s1_hit_cnt", 64'(hit_cnt), 64'd2);
`endif

        // 2: back-to-back throughput, 512 vectors
        d0 = n_deliv;
        t0 = 0;
        for (int i = 0; i < 512; i++) begin
            x = 9'(i);
            in_valid = 1'b1;
            @(negedge clk);
            if (i == 0) t0 = cyc;
            check("s2_in_ready", 64'(in_ready), 64'd1);
            tick();
        end
        in_valid = 1'b0;
        drain();
        check("s2_n_results", 64'(n_deliv - d0), 64'd512);
        check("s2_span", 64'(last_deliv - t0), 64'd513);

        // 3: backpressure with a full pipeline
        chk_lat = 1'b0;
        out_ready = 1'b0;
        x = 9'h00F; in_valid = 1'b1;
        tick();
        x = 9'h01F;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("s3_in_ready_low", 64'(in_ready), 64'd0);
            check("s3_hold_valid", 64'(out_valid), 64'd1);
            check("s3_hold_y0", 64'(y0), 64'd1);
            check("s3_hold_count", 64'(count), 64'd4);
            tick();
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("s3_rel_count0", 64'(count), 64'd4);
        check("s3_rel_in_ready", 64'(in_ready), 64'd1);
        tick();
        @(negedge clk);
        check("s3_rel_valid1", 64'(out_valid), 64'd1);
        check("s3_rel_count1", 64'(count), 64'd5);
        tick();
        @(negedge clk);
        check("s3_no_dup", 64'(out_valid), 64'd0);
        drain();

        // 4: mask write in the same cycle as an accept
        chk_lat = 1'b1;
        x = 9'h003; in_valid = 1'b1; cfg_we = 1'b1; cfg_mask = 10'h004;
        tick();
        cfg_we = 1'b0;
        @(negedge clk);
        check("s4_mask_q", 64'(mask_q), 64'h004);
        tick();
        in_valid = 1'b0;
        drain();

        // 5: reset while both stages are full; the same-cycle cfg_we is
        // ignored
        chk_lat = 1'b0;
        out_ready = 1'b0;
        x = 9'h00F; in_valid = 1'b1;
        tick();
        x = 9'h01F;
        tick();
        in_valid = 1'b0;
        rst = 1'b1; cfg_we = 1'b1; cfg_mask = 10'h3FF;
        tick();
        rst = 1'b0; cfg_we = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        check("s5_out_valid", 64'(out_valid), 64'd0);
        check("s5_mask_q", 64'(mask_q), 64'h078);
        tick();
        x = 9'h1FF; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        drain();

`ifdef SYM_EVAL_HIT_CNT_EN
        // 6: clear coincident with a hit, then saturation
        out_ready = 1'b0;
        x = 9'h007; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b1; hit_clr = 1'b1;
        tick();
        hit_clr = 1'b0;
        @(negedge clk);
        check("s6_hit_clr", 64'(hit_cnt), 64'd0);
        tick();
        force dut.r_hit_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_hit_cnt;
        model_hits = 32'hFFFF_FFFE;
        for (int i = 0; i < 3; i++) begin
            x = 9'h007; in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        drain();
        check("s6_hit_sat", 64'(hit_cnt), 64'hFFFF_FFFF);
        check("s6_hit_model", 64'(hit_cnt), 64'(model_hits));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
